tile_fill_master: RTL

// - Avalon-MM write initiator feeding the tile table slave port: fills a rectangle of tile entries with one 11-bit word.
// - Word format: [10:8] palette, [7:0] pattern index.
// - Command in from CPU glue or the boot sequencer; writes issued in raster order, one per accepted bus cycle.
// - Used for screen clears, window backgrounds and boot-time tile initialisation; replaces per-tile CPU writes.

---
 rtl/tile_fill_master_if.sv | 27 ++
 rtl/tile_fill_master.sv | 78 +++++++
 2 files changed

// File: rtl/tile_fill_master_if.sv
// tile_fill_master_if: command, status and Avalon-MM write bus of the tile fill engine
interface tile_fill_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x0;
  logic [4:0]  cmd_y0;
  logic [6:0]  cmd_w;
  logic [4:0]  cmd_h;
  logic [10:0] cmd_data;
  logic        busy;
  logic        done;
  logic [11:0] fill_count;
  logic [12:0] M_ADDR;
  logic        M_CS;
  logic        M_WRITE;
  logic [31:0] M_WRITEDATA;
  logic [3:0]  M_BYTE_EN;
  logic        M_WAITREQUEST;
  modport master (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_data, M_WAITREQUEST,
    output cmd_ready, busy, done, fill_count, M_ADDR, M_CS, M_WRITE, M_WRITEDATA, M_BYTE_EN
  );
  modport slave (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_data, M_WAITREQUEST,
    input  cmd_ready, busy, done, fill_count, M_ADDR, M_CS, M_WRITE, M_WRITEDATA, M_BYTE_EN
  );
endinterface

// File: rtl/tile_fill_master.sv
// tile_fill_master: raster-order rectangle fill of the tile table; TILE_FILL_CLIP_EN skips off-screen tiles
module tile_fill_master #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input logic CLK_100,
  input logic RESET,
  tile_fill_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, next_state;
  logic [6:0] x0_q;
  logic [7:0] x_last, cur_x;
  logic [5:0] y_last, cur_y;
  logic [10:0] data_q;
  logic [11:0] cnt;
  logic done_q, accept, empty, skip, wr, adv, last_tile, row_end;
  if (COLS > 128 || ROWS > 32) begin : g_geometry_check
    $error("tile_fill_master: COLS/ROWS exceed the 7/5-bit address fields");
  end
  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign empty     = bus.cmd_w == 7'd0 || bus.cmd_h == 5'd0;
  assign row_end   = cur_x == x_last;
  assign last_tile = row_end && cur_y == y_last;
`ifdef TILE_FILL_CLIP_EN
  assign skip = cur_x >= 8'(COLS) || cur_y >= 6'(ROWS);
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge CLK_100)
    if (RESET) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state == IDLE  ? (accept ? (empty ? DONE : WRITE) : IDLE)
               : state == WRITE ? (adv && last_tile ? DONE : WRITE)
               : IDLE;
  end
  always_comb begin
    wr               = state == WRITE && !skip;
    adv              = state == WRITE && (!wr || !bus.M_WAITREQUEST);
    bus.M_WRITE      = wr;
    bus.M_CS         = wr;
    bus.busy         = state == WRITE;
    bus.cmd_ready    = state == IDLE && !done_q;
    bus.done         = done_q;
    bus.fill_count   = cnt;
    bus.M_ADDR       = {cur_y[4:0], 1'b0, cur_x[6:0]};
    bus.M_WRITEDATA  = {21'b0, data_q};
    bus.M_BYTE_EN    = 4'b0011;
  end
  // Counters carry one extra bit so x0+w and y0+h never wrap back on screen.
  always_ff @(posedge CLK_100)
    if (RESET) begin
      x0_q   <= '0;
      x_last <= '0;
      y_last <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      data_q <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == DONE;
      if (accept) begin
        x0_q   <= bus.cmd_x0;
        x_last <= {1'b0, bus.cmd_x0} + {1'b0, bus.cmd_w} - 8'd1;
        y_last <= {1'b0, bus.cmd_y0} + {1'b0, bus.cmd_h} - 6'd1;
        cur_x  <= {1'b0, bus.cmd_x0};
        cur_y  <= {1'b0, bus.cmd_y0};
        data_q <= bus.cmd_data;
        cnt    <= '0;
      end else if (adv) begin
        cur_x <= row_end ? {1'b0, x0_q} : cur_x + 8'd1;
        cur_y <= row_end ? cur_y + 6'd1 : cur_y;
        cnt   <= cnt + 12'(wr);
      end
    end
endmodule
